// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state encodings, opcodes and datapath select codes
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_ALU_WB, S_HALT, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_RS1  = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;

  // Next state out of DECODE; unknown opcodes land in TRAP.
  function automatic state_t dispatch(input logic [6:0] opcode, input logic halt_on_ecall);
    state_t s;
    case (opcode)
      OP_R:      s = S_EXEC_R;
      OP_IMM:    s = S_EXEC_I;
      OP_LOAD,
      OP_STORE:  s = S_MEM_ADDR;
      OP_BRANCH: s = S_BRANCH;
      OP_JAL:    s = S_JAL;
      OP_JALR:   s = S_JALR;
      OP_LUI:    s = S_LUI;
      OP_AUIPC:  s = S_AUIPC;
      OP_SYSTEM: s = halt_on_ecall ? S_HALT : S_FETCH;
      default:   s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/branch_eval.sv
// rtl/branch_eval.sv - branch condition decode from funct3 and ALU compare flags
module branch_eval
  import ctrl_pkg::*;
#(
  parameter bit BRANCH_ALL = 1'b1
) (
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  output logic       o_taken,
  output logic       o_bad
);

  always_comb begin
    o_taken = 1'b0;
    o_bad   = 1'b0;
    if (BRANCH_ALL) begin
      case (i_funct3)
        F3_BEQ:  o_taken = i_zero;
        F3_BNE:  o_taken = !i_zero;
        F3_BLT:  o_taken = i_lt;
        F3_BGE:  o_taken = !i_lt;
        F3_BLTU: o_taken = i_ltu;
        F3_BGEU: o_taken = !i_ltu;
        default: o_bad   = 1'b1;
      endcase
    end else begin
      // Reduced decoder: only beq can ever redirect the PC.
      o_taken = (i_funct3 == F3_BEQ) && i_zero;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for a multicycle RV32I datapath
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter bit BRANCH_ALL    = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_mem_ready,
  input  logic        i_zero,
  input  logic        i_lt,
  input  logic        i_ltu,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_reg_write,
  output logic        o_iord,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_alu_op,
  output logic [1:0]  o_wb_sel,
  output logic [1:0]  o_pc_src,
  output logic [3:0]  o_state,
  output logic        o_halted,
  output logic        o_illegal
);

  state_t r_state;
  logic   r_run;
  logic   r_halted;
  logic   r_illegal;

  logic   w_mem_done;
  logic   w_taken;
  logic   w_bad;
  state_t w_dispatch;
  logic   w_unused_instr;

  assign w_mem_done     = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
  assign w_dispatch     = dispatch(i_instr[6:0], HALT_ON_ECALL);
  assign w_unused_instr = ^{i_instr[31:15], i_instr[11:7]};

  branch_eval #(.BRANCH_ALL(BRANCH_ALL)) u_branch_eval (
    .i_funct3 (i_instr[14:12]),
    .i_zero   (i_zero),
    .i_lt     (i_lt),
    .i_ltu    (i_ltu),
    .o_taken  (w_taken),
    .o_bad    (w_bad)
  );

  // r_run holds the FSM idle for the first edge after reset release so
  // the first FETCH starts cleanly on the following rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_run     <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      case (r_state)
        S_FETCH:    if (w_mem_done) r_state <= S_DECODE;
        S_DECODE: begin
          r_state <= w_dispatch;
          if (w_dispatch == S_TRAP) r_illegal <= 1'b1;
          if (w_dispatch == S_HALT) r_halted  <= 1'b1;
        end
        S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: r_state <= S_ALU_WB;
        S_MEM_ADDR: r_state <= i_instr[5] ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (w_mem_done) r_state <= S_MEM_WB;
        S_MEM_WR:   if (w_mem_done) r_state <= S_FETCH;
        S_MEM_WB, S_ALU_WB, S_JAL, S_JALR: r_state <= S_FETCH;
        S_BRANCH: begin
          if (w_bad) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        default:    r_state <= r_state;
      endcase
    end
  end

  always_comb begin
    o_ir_write  = 1'b0;
    o_pc_write  = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_reg_write = 1'b0;
    o_iord      = 1'b0;
    o_alu_src_a = SRCA_PC;
    o_alu_src_b = SRCB_RS2;
    o_alu_op    = ALU_ADD;
    o_wb_sel    = WB_ALU;
    o_pc_src    = PCSRC_ALU;
    if (r_run) begin
      case (r_state)
        S_FETCH: begin
          o_mem_read  = 1'b1;
          o_ir_write  = w_mem_done;
          o_pc_write  = w_mem_done;
          o_alu_src_b = SRCB_FOUR;
        end
        S_DECODE:   o_alu_src_b = SRCB_IMM;
        S_EXEC_R: begin
          o_alu_src_a = SRCA_RS1;
          o_alu_op    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          o_alu_src_a = SRCA_RS1;
          o_alu_src_b = SRCB_IMM;
          o_alu_op    = ALU_FUNCT;
        end
        S_MEM_ADDR: begin
          o_alu_src_a = SRCA_RS1;
          o_alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        S_MEM_WB: begin
          o_reg_write = 1'b1;
          o_wb_sel    = WB_MEM;
        end
        S_MEM_WR: begin
          o_mem_write = 1'b1;
          o_iord      = 1'b1;
        end
        S_BRANCH: begin
          o_alu_src_a = SRCA_RS1;
          o_alu_op    = ALU_CMP;
          o_pc_src    = PCSRC_ALUOUT;
          o_pc_write  = w_taken;
        end
        S_JAL: begin
          o_reg_write = 1'b1;
          o_wb_sel    = WB_PC4;
          o_pc_write  = 1'b1;
          o_pc_src    = PCSRC_ALUOUT;
        end
        S_JALR: begin
          o_reg_write = 1'b1;
          o_wb_sel    = WB_PC4;
          o_pc_write  = 1'b1;
          o_pc_src    = PCSRC_JALR;
          o_alu_src_a = SRCA_RS1;
          o_alu_src_b = SRCB_IMM;
        end
        S_LUI: begin
          o_alu_src_a = SRCA_ZERO;
          o_alu_src_b = SRCB_IMM;
        end
        S_AUIPC:    o_alu_src_b = SRCB_IMM;
        S_ALU_WB:   o_reg_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_halted  = r_halted;
  assign o_illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0;

  logic       a_ir_write, a_pc_write, a_mem_read, a_mem_write, a_reg_write, a_iord, a_halted, a_illegal;
  logic [1:0] a_alu_src_a, a_alu_src_b, a_alu_op, a_wb_sel, a_pc_src;
  logic [3:0] a_state;
  logic       b_ir_write, b_pc_write, b_mem_read, b_mem_write, b_reg_write, b_iord, b_halted, b_illegal;
  logic [1:0] b_alu_src_a, b_alu_src_b, b_alu_op, b_wb_sel, b_pc_src;
  logic [3:0] b_state;

  multicycle_control dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_mem_ready(mem_ready),
    .i_zero(zero), .i_lt(lt), .i_ltu(ltu),
    .o_ir_write(a_ir_write), .o_pc_write(a_pc_write), .o_mem_read(a_mem_read),
    .o_mem_write(a_mem_write), .o_reg_write(a_reg_write), .o_iord(a_iord),
    .o_alu_src_a(a_alu_src_a), .o_alu_src_b(a_alu_src_b), .o_alu_op(a_alu_op),
    .o_wb_sel(a_wb_sel), .o_pc_src(a_pc_src), .o_state(a_state),
    .o_halted(a_halted), .o_illegal(a_illegal)
  );

  multicycle_control #(.BRANCH_ALL(1'b0), .MEM_HANDSHAKE(1'b0), .HALT_ON_ECALL(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_mem_ready(mem_ready),
    .i_zero(zero), .i_lt(lt), .i_ltu(ltu),
    .o_ir_write(b_ir_write), .o_pc_write(b_pc_write), .o_mem_read(b_mem_read),
    .o_mem_write(b_mem_write), .o_reg_write(b_reg_write), .o_iord(b_iord),
    .o_alu_src_a(b_alu_src_a), .o_alu_src_b(b_alu_src_b), .o_alu_op(b_alu_op),
    .o_wb_sel(b_wb_sel), .o_pc_src(b_pc_src), .o_state(b_state),
    .o_halted(b_halted), .o_illegal(b_illegal)
  );

  wire [4:0]  a_sb  = {a_ir_write, a_pc_write, a_mem_read, a_mem_write, a_reg_write};
  wire [4:0]  b_sb  = {b_ir_write, b_pc_write, b_mem_read, b_mem_write, b_reg_write};
  wire [10:0] a_sel = {a_alu_src_a, a_alu_src_b, a_alu_op, a_wb_sel, a_pc_src, a_iord};
  wire [10:0] b_sel = {b_alu_src_a, b_alu_src_b, b_alu_op, b_wb_sel, b_pc_src, b_iord};

  // strobe words {ir_write, pc_write, mem_read, mem_write, reg_write}
  localparam logic [4:0] FE = 5'b11100, NO = 5'b00000, RW = 5'b00001, MR = 5'b00100;
  localparam logic [4:0] MW = 5'b00010, PW = 5'b01000, JW = 5'b01001;

  typedef struct {
    string       nm;
    int          dut;
    logic [31:0] ins;
    logic [2:0]  fl;
    logic        rdy;
    int          n;
    logic [23:0] st;
    logic [29:0] sb;
    logic [1:0]  hi;
  } vec_t;

  typedef struct {
    string      nm;
    int         dut;
    int         k;
    logic [3:0] st;
    logic [4:0] sb;
  } exp_t;

  vec_t tv[$];
  exp_t sbq[$];
  exp_t m;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input int dut, input logic [31:0] ins, input logic [2:0] fl,
                     input logic rdy, input int n, input logic [23:0] st, input logic [29:0] sb,
                     input logic [1:0] hi);
    vec_t v;
    v.nm = nm; v.dut = dut; v.ins = ins; v.fl = fl; v.rdy = rdy;
    v.n = n; v.st = st; v.sb = sb; v.hi = hi;
    tv.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_a(input state_t s, input string nm);
    logic ok;
    int   c;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < 12) begin
      @(negedge clk);
      if (a_state == s) ok = 1'b1;
      c++;
    end
    chk({nm, "_reached"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   c;
    instr = v.ins;
    {zero, lt, ltu} = v.fl;
    mem_ready = v.rdy;
    do_reset();
    @(posedge clk);
    for (int k = 0; k < v.n; k++) begin
      e.nm = v.nm; e.dut = v.dut; e.k = k;
      e.st = v.st[23-4*k -: 4];
      e.sb = v.sb[29-5*k -: 5];
      sbq.push_back(e);
    end
    c = 0;
    while (sbq.size() > 0 && c < v.n + 4) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain: %0d entries left, expected 0", v.nm, sbq.size());
      sbq.delete();
    end
    chk({v.nm, "_flags"}, (v.dut == 0) ? {30'b0, a_halted, a_illegal} : {30'b0, b_halted, b_illegal},
        {30'b0, v.hi});
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (sbq.size() > 0) begin
          m = sbq.pop_front();
          chk($sformatf("%s[%0d]", m.nm, m.k),
              (m.dut == 0) ? {23'b0, a_state, a_sb} : {23'b0, b_state, b_sb},
              {23'b0, m.st, m.sb});
        end
      end
    join_none

    // default-parameter instance, memory always ready
    add("add",    0, 32'h002081B3, 3'b000, 1'b1, 5, {S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_FETCH, S_FETCH}, {FE, NO, NO, RW, FE, NO}, 2'b00);
    add("addi",   0, 32'h00108093, 3'b000, 1'b1, 5, {S_FETCH, S_DECODE, S_EXEC_I, S_ALU_WB, S_FETCH, S_FETCH}, {FE, NO, NO, RW, FE, NO}, 2'b00);
    add("lw",     0, 32'h0000A183, 3'b000, 1'b1, 6, {S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_FETCH}, {FE, NO, NO, MR, RW, FE}, 2'b00);
    add("sw",     0, 32'h0020A023, 3'b000, 1'b1, 5, {S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_FETCH, S_FETCH}, {FE, NO, NO, MW, FE, NO}, 2'b00);
    add("beq_t",  0, 32'h00208063, 3'b100, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, PW, FE, NO, NO}, 2'b00);
    add("beq_n",  0, 32'h00208063, 3'b000, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, NO, FE, NO, NO}, 2'b00);
    add("bne_t",  0, 32'h00209063, 3'b000, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, PW, FE, NO, NO}, 2'b00);
    add("bne_n",  0, 32'h00209063, 3'b100, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, NO, FE, NO, NO}, 2'b00);
    add("blt_t",  0, 32'h0020C063, 3'b010, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, PW, FE, NO, NO}, 2'b00);
    add("bge_n",  0, 32'h0020D063, 3'b010, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, NO, FE, NO, NO}, 2'b00);
    add("bltu_n", 0, 32'h0020E063, 3'b000, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, NO, FE, NO, NO}, 2'b00);
    add("bgeu_t", 0, 32'h0020F063, 3'b000, 1'b1, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, PW, FE, NO, NO}, 2'b00);
    add("jal",    0, 32'h000000EF, 3'b000, 1'b1, 4, {S_FETCH, S_DECODE, S_JAL, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, JW, FE, NO, NO}, 2'b00);
    add("jalr",   0, 32'h000080E7, 3'b000, 1'b1, 4, {S_FETCH, S_DECODE, S_JALR, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, JW, FE, NO, NO}, 2'b00);
    add("lui",    0, 32'h000010B7, 3'b000, 1'b1, 5, {S_FETCH, S_DECODE, S_LUI, S_ALU_WB, S_FETCH, S_FETCH}, {FE, NO, NO, RW, FE, NO}, 2'b00);
    add("auipc",  0, 32'h00001097, 3'b000, 1'b1, 5, {S_FETCH, S_DECODE, S_AUIPC, S_ALU_WB, S_FETCH, S_FETCH}, {FE, NO, NO, RW, FE, NO}, 2'b00);
    add("ecall",  0, 32'h00000073, 3'b000, 1'b1, 5, {S_FETCH, S_DECODE, S_HALT, S_HALT, S_HALT, S_FETCH}, {FE, NO, NO, NO, NO, NO}, 2'b10);
    add("ill",    0, 32'h0000007F, 3'b111, 1'b1, 5, {S_FETCH, S_DECODE, S_TRAP, S_TRAP, S_TRAP, S_FETCH}, {FE, NO, NO, NO, NO, NO}, 2'b01);
    add("br010",  0, 32'h0020A063, 3'b111, 1'b1, 5, {S_FETCH, S_DECODE, S_BRANCH, S_TRAP, S_TRAP, S_FETCH}, {FE, NO, NO, NO, NO, NO}, 2'b01);
    // reduced instance: beq only, no handshake, ecall is a no-op
    add("b_lw",    1, 32'h0000A183, 3'b000, 1'b0, 6, {S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_FETCH}, {FE, NO, NO, MR, RW, FE}, 2'b00);
    add("b_blt",   1, 32'h0020C063, 3'b010, 1'b0, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, NO, FE, NO, NO}, 2'b00);
    add("b_beq",   1, 32'h00208063, 3'b100, 1'b0, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, PW, FE, NO, NO}, 2'b00);
    add("b_br010", 1, 32'h0020A063, 3'b111, 1'b0, 4, {S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, S_FETCH}, {FE, NO, NO, FE, NO, NO}, 2'b00);
    add("b_ecall", 1, 32'h00000073, 3'b000, 1'b0, 4, {S_FETCH, S_DECODE, S_FETCH, S_DECODE, S_FETCH, S_FETCH}, {FE, NO, FE, NO, NO, NO}, 2'b00);

    for (int i = 0; i < tv.size(); i++) run_vec(tv[i]);

    // FETCH stalls on mem_ready; mem_ready is ignored outside memory states
    instr = 32'h002081B3; mem_ready = 1'b0;
    do_reset();
    #1;
    chk("rst_state", {28'b0, a_state}, {28'b0, S_FETCH});
    chk("rst_strobes", {27'b0, a_sb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("fetch_wait", {23'b0, a_state, a_sb}, {23'b0, S_FETCH, 5'b00100});
    chk("fetch_sel", {21'b0, a_sel}, {21'b0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0});
    chk("b_fetch_sel", {21'b0, b_sel}, {21'b0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0});
    @(negedge clk);
    chk("fetch_wait2", {23'b0, a_state, a_sb}, {23'b0, S_FETCH, 5'b00100});
    mem_ready = 1'b1;
    #1;
    chk("fetch_done", {27'b0, a_sb}, {27'b0, FE});
    @(negedge clk);
    mem_ready = 1'b0;
    chk("decode_sel", {17'b0, a_state, a_sel}, {17'b0, S_DECODE, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0});
    @(negedge clk);
    chk("exec_r_sel", {17'b0, a_state, a_sel}, {17'b0, S_EXEC_R, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0});
    @(negedge clk);
    chk("alu_wb", {25'b0, a_state, a_reg_write, a_wb_sel}, {25'b0, S_ALU_WB, 1'b1, 2'd0});

    // load with MEM_RD stretched to three cycles
    instr = 32'h0000A183; mem_ready = 1'b1;
    do_reset();
    wait_a(S_MEM_ADDR, "lw_addr");
    chk("mem_addr_sel", {21'b0, a_sel}, {21'b0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0});
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("lw_wait%0d", c), {25'b0, a_state, a_mem_read, a_iord, a_reg_write},
          {25'b0, S_MEM_RD, 1'b1, 1'b1, 1'b0});
      if (c == 2) mem_ready = 1'b1;
    end
    @(negedge clk);
    chk("lw_wb", {24'b0, a_state, a_wb_sel, a_reg_write, a_mem_read}, {24'b0, S_MEM_WB, 2'd1, 1'b1, 1'b0});

    // branch and jalr select codes
    instr = 32'h00209063; {zero, lt, ltu} = 3'b000; mem_ready = 1'b1;
    do_reset();
    wait_a(S_BRANCH, "bne_br");
    chk("branch_sel", {20'b0, a_pc_write, a_sel}, {20'b0, 1'b1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 1'b0});
    instr = 32'h000080E7;
    do_reset();
    wait_a(S_JALR, "jalr_st");
    chk("jalr_sel", {21'b0, a_sel}, {21'b0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd2, 1'b0});

    // asynchronous reset in the middle of a stalled store
    instr = 32'h0020A023; mem_ready = 1'b1;
    do_reset();
    wait_a(S_MEM_ADDR, "sw_addr");
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_wait", {27'b0, a_state, a_mem_write}, {27'b0, S_MEM_WR, 1'b1});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {21'b0, a_state, a_sb, a_halted, a_illegal}, {21'b0, S_FETCH, 5'b0, 2'b0});
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_release_idle", {27'b0, a_sb}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_fetch", {23'b0, a_state, a_sb}, {23'b0, S_FETCH, FE});

    // sticky illegal is cleared by reset
    instr = 32'h0000007F;
    do_reset();
    repeat (4) @(negedge clk);
    chk("ill_sticky", {30'b0, a_halted, a_illegal}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ill_cleared", {30'b0, a_halted, a_illegal}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
